// File: rtl/sme_pkg.sv
// Shared definitions for the SME writeback path: share geometry, FSM state
// encoding and the per-share data type.
package sme_pkg;

  localparam int XLEN = 32;
  localparam int SMAX = 4;
  localparam int SW   = $clog2(SMAX);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_t;

  typedef logic [XLEN-1:0] share_t;

endpackage

// File: rtl/sme_wb_serialiser.sv
// SME writeback serialiser: captures a masked result vector and writes each share
// separately through the arbitrated share register file. Optional: SME_WB_ZEROISE_EN.
module sme_wb_serialiser
  import sme_pkg::*;
(
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 flush,
  input  logic [3:0]           smectl_d,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_addr,
  input  logic [SMAX*XLEN-1:0] in_rd,
  output logic                 rf_wen,
  input  logic                 rf_gnt,
  output logic [4:0]           rf_waddr,
  output logic [SW-1:0]        rf_wshare,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 busy,
  output logic                 done
);

  wb_state_t   state, state_nxt;
  share_t      shares [SMAX];
  logic [4:0]  addr;
  logic [SW:0] cnt;
  logic [SW-1:0] idx;
  logic        accept;
  logic        advance;
  logic        last;
  logic        zero_addr;

  // Requested share count forced into 1..SMAX.
  function automatic logic [SW:0] clamp_count(input logic [3:0] req);
    if (req == 4'd0)
      return (SW+1)'(1);
    else if (int'(req) > SMAX)
      return (SW+1)'(SMAX);
    else
      return (SW+1)'(req);
  endfunction

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    rf_wen    = 1'b0;
    done      = 1'b0;
    advance   = 1'b0;
    busy      = (state == WRITE);
    zero_addr = (addr == 5'd0);
    last      = ({1'b0, idx} == (cnt - (SW+1)'(1)));
    case (state)
      IDLE: begin
        in_ready = !flush;
      end
      WRITE: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (zero_addr) begin
          // Writes to register 0 are dropped but still complete the transaction.
          done      = 1'b1;
          in_ready  = 1'b1;
          state_nxt = IDLE;
        end else begin
          rf_wen = 1'b1;
          if (rf_gnt) begin
            if (last) begin
              done      = 1'b1;
              in_ready  = 1'b1;
              state_nxt = IDLE;
            end else begin
              advance = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_valid && in_ready;
    if (accept)
      state_nxt = WRITE;
  end

  assign rf_waddr  = addr;
  assign rf_wshare = idx;
`ifdef SME_WB_ZEROISE_EN
  assign rf_wdata  = rf_wen ? shares[idx] : '0;
`else
  assign rf_wdata  = shares[idx];
`endif

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      idx   <= '0;
      for (int i = 0; i < SMAX; i++)
        shares[i] <= '0;
    end else begin
      state <= state_nxt;
      if (advance)
        idx <= idx + SW'(1);
      else if (state_nxt == IDLE)
        idx <= '0;
`ifdef SME_WB_ZEROISE_EN
      // Each share lives in the holding register no longer than necessary.
      if (done || flush) begin
        for (int i = 0; i < SMAX; i++)
          shares[i] <= '0;
      end else if (rf_wen && rf_gnt) begin
        shares[idx] <= '0;
      end
`endif
      if (accept) begin
        for (int i = 0; i < SMAX; i++)
          shares[i] <= in_rd[i*XLEN +: XLEN];
        addr <= in_addr;
        cnt  <= clamp_count(smectl_d);
        idx  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sme_wb_serialiser.sv
// Directed self-checking bench for sme_wb_serialiser with hand-computed expectations.
module tb_sme_wb_serialiser;
  import sme_pkg::*;

  logic                 g_clk;
  logic                 g_resetn;
  logic                 flush;
  logic [3:0]           smectl_d;
  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_addr;
  logic [SMAX*XLEN-1:0] in_rd;
  logic                 rf_wen;
  logic                 rf_gnt;
  logic [4:0]           rf_waddr;
  logic [SW-1:0]        rf_wshare;
  logic [XLEN-1:0]      rf_wdata;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  localparam logic [XLEN-1:0] SA = 32'hAAAA0001;
  localparam logic [XLEN-1:0] SB = 32'hBBBB0002;
  localparam logic [XLEN-1:0] SC = 32'hCCCC0003;
  localparam logic [XLEN-1:0] SD = 32'hDDDD0004;
  localparam logic [XLEN-1:0] SE = 32'h11110005;

  sme_wb_serialiser dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .smectl_d  (smectl_d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_rd     (in_rd),
    .rf_wen    (rf_wen),
    .rf_gnt    (rf_gnt),
    .rf_waddr  (rf_waddr),
    .rf_wshare (rf_wshare),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .done      (done)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge and return inputs to their idle defaults.
  task automatic tick();
    @(posedge g_clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    rf_gnt   = 1'b1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic offer(input logic [4:0] a, input logic [3:0] n,
                       input logic [SMAX*XLEN-1:0] rd);
    tick();
    in_valid = 1'b1;
    in_addr  = a;
    smectl_d = n;
    in_rd    = rd;
    settle();
    chk("accept_ready", in_ready, 1'b1);
  endtask

  task automatic chk_write(input string tag, input logic [4:0] a,
                           input logic [SW-1:0] s, input logic [XLEN-1:0] d,
                           input logic dn);
    chk({tag, "_wen"},   rf_wen,    1'b1);
    chk({tag, "_waddr"}, rf_waddr,  a);
    chk({tag, "_share"}, rf_wshare, s);
    chk({tag, "_wdata"}, rf_wdata,  d);
    chk({tag, "_done"},  done,      dn);
  endtask

  // Run with grant held until done; report granted writes, cycles and final share.
  task automatic run_to_done(output int writes, output int cycles, output logic [SW-1:0] last_s);
    writes = 0;
    cycles = 0;
    last_s = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      settle();
      if (rf_wen && rf_gnt) begin
        writes++;
        last_s = rf_wshare;
      end
      if (done) begin
        cycles = c;
        break;
      end
    end
  endtask

  int              nw, nc;
  logic [SW-1:0]   ls;

  initial begin
    g_resetn = 1'b0;
    flush    = 1'b0;
    smectl_d = 4'd0;
    in_valid = 1'b0;
    in_addr  = 5'd0;
    in_rd    = '0;
    rf_gnt   = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_wen",      rf_wen,   1'b0);
    chk("rst_busy",     busy,     1'b0);
    chk("rst_done",     done,     1'b0);
    chk("rst_waddr",    rf_waddr, 5'd0);
    chk("rst_wdata",    rf_wdata, 32'd0);
    chk("rst_share",    rf_wshare, '0);
    @(posedge g_clk);
    @(posedge g_clk);
    #3;
    g_resetn = 1'b1;

    // Three of four shares, continuous grant.
    offer(5'd5, 4'd3, {SD, SC, SB, SA});
    tick(); settle(); chk_write("t1w0", 5'd5, 2'd0, SA, 1'b0);
    chk("t1_busy", busy, 1'b1);
    tick(); settle(); chk_write("t1w1", 5'd5, 2'd1, SB, 1'b0);
    tick(); settle(); chk_write("t1w2", 5'd5, 2'd2, SC, 1'b1);
    tick(); settle();
    chk("t1_idle_wen",   rf_wen,   1'b0);
    chk("t1_idle_busy",  busy,     1'b0);
    chk("t1_idle_ready", in_ready, 1'b1);
    chk("t1_idle_done",  done,     1'b0);
`ifdef SME_WB_ZEROISE_EN
    chk("t1_zero_wdata", rf_wdata, 32'd0);
    chk("t1_zero_sh0",   dut.shares[0], 32'd0);
    chk("t1_zero_sh3",   dut.shares[3], 32'd0);
`else
    chk("t1_stale_wdata", rf_wdata, SA);
`endif

    // Four shares with a two-cycle grant stall on share 1.
    offer(5'd6, 4'd4, {SD, SC, SB, SA});
    tick(); settle(); chk_write("t2w0", 5'd6, 2'd0, SA, 1'b0);
    tick(); rf_gnt = 1'b0; settle(); chk_write("t2s1", 5'd6, 2'd1, SB, 1'b0);
    tick(); rf_gnt = 1'b0; settle(); chk_write("t2s2", 5'd6, 2'd1, SB, 1'b0);
    tick(); settle(); chk_write("t2w1", 5'd6, 2'd1, SB, 1'b0);
    tick(); settle(); chk_write("t2w2", 5'd6, 2'd2, SC, 1'b0);
    tick(); settle(); chk_write("t2w3", 5'd6, 2'd3, SD, 1'b1);

    // Back-to-back: next result offered during the final write.
    offer(5'd3, 4'd2, {SD, SC, SB, SA});
    tick(); settle(); chk_write("t3w0", 5'd3, 2'd0, SA, 1'b0);
    tick();
    in_valid = 1'b1; in_addr = 5'd7; smectl_d = 4'd1; in_rd = {SD, SC, SB, SE};
    settle();
    chk_write("t3w1", 5'd3, 2'd1, SB, 1'b1);
    chk("t3_b2b_ready", in_ready, 1'b1);
    tick(); settle(); chk_write("t3n0", 5'd7, 2'd0, SE, 1'b1);
    tick(); settle(); chk("t3_end_wen", rf_wen, 1'b0);

    // Flush at share 1.
    offer(5'd9, 4'd4, {SD, SC, SB, SA});
    tick(); settle(); chk_write("t4w0", 5'd9, 2'd0, SA, 1'b0);
    tick(); flush = 1'b1; settle();
    chk("t4_fl_wen",   rf_wen,   1'b0);
    chk("t4_fl_done",  done,     1'b0);
    chk("t4_fl_ready", in_ready, 1'b0);
    tick(); settle();
    chk("t4_post_busy",  busy,     1'b0);
    chk("t4_post_wen",   rf_wen,   1'b0);
    chk("t4_post_done",  done,     1'b0);
    chk("t4_post_ready", in_ready, 1'b1);

    // Flush in IDLE blocks a simultaneous offer.
    tick();
    in_valid = 1'b1; in_addr = 5'd8; smectl_d = 4'd2; flush = 1'b1;
    settle();
    chk("t4i_ready", in_ready, 1'b0);
    tick(); settle();
    chk("t4i_busy", busy,   1'b0);
    chk("t4i_wen",  rf_wen, 1'b0);

    // Register 0: completes with no write.
    offer(5'd0, 4'd2, {SD, SC, SB, SA});
    tick(); settle();
    chk("t5a_wen",  rf_wen, 1'b0);
    chk("t5a_done", done,   1'b1);
    tick(); settle();
    chk("t5a_busy", busy,   1'b0);
    chk("t5a_done2", done,  1'b0);

    // smectl_d = 0 behaves as a single share.
    offer(5'd4, 4'd0, {SD, SC, SB, SA});
    run_to_done(nw, nc, ls);
    chk("t5b_writes", nw, 1);
    chk("t5b_cycles", nc, 1);
    chk("t5b_share",  ls, 2'd0);

    // smectl_d above SMAX saturates to SMAX.
    offer(5'd10, 4'd9, {SD, SC, SB, SA});
    run_to_done(nw, nc, ls);
    chk("t5c_writes", nw, 4);
    chk("t5c_cycles", nc, 4);
    chk("t5c_share",  ls, 2'd3);

    // Asynchronous reset mid-WRITE.
    offer(5'd11, 4'd4, {SD, SC, SB, SA});
    tick(); settle(); chk_write("t6w0", 5'd11, 2'd0, SA, 1'b0);
    #1;
    g_resetn = 1'b0;
    #1;
    chk("t6_rst_wen",   rf_wen,   1'b0);
    chk("t6_rst_busy",  busy,     1'b0);
    chk("t6_rst_ready", in_ready, 1'b1);
    chk("t6_rst_waddr", rf_waddr, 5'd0);
    #10;
    g_resetn = 1'b1;
    tick(); settle();
    chk("t6_after_wen", rf_wen, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
